uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, holding-FIFO entries (power of 2, range 2..16).
REQ-002 SHALL have parameter PARITY_EN, default 1, where 1 inserts an even-parity bit and 0 omits it.
REQ-003 SHALL have port clk  input  1  system clock, with all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port baud_tick  input  1  single-cycle pulse in the clk domain, one per bit period.
REQ-006 SHALL have port in_data  input  8  byte to transmit.
REQ-007 SHALL have port in_valid  input  1  in_data is valid.
REQ-008 SHALL have port in_ready  output  1  the FIFO can accept a byte.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  a frame is in progress or the FIFO is non-empty.
REQ-011 SHALL have port tx_done  output  1  one-clk pulse when a stop bit completes.

Function
REQ-012 SHALL accept a byte on any clk edge where in_valid=1 and in_ready=1.
REQ-013 SHALL drive in_ready = !fifo_full, with no dependence on a same-cycle pop; a push while full is dropped and not an error.
REQ-014 SHALL use a frame of start(0), d[7]..d[0] MSB-first, parity (if PARITY_EN), stop(1): 11 bit periods, or 10 with PARITY_EN=0.
REQ-015 SHALL compute parity = ^d[7:0] (even parity over data bits only).
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP; every transition and every tx change SHALL occur only on clk edges with baud_tick=1.
REQ-017 SHALL, in IDLE on baud_tick with FIFO non-empty: pop the FIFO, load the shift register, set tx<=0, go to START, and set bit_cnt<=7.
REQ-018 SHALL, in START on baud_tick: set tx<=d[7] and go to DATA.
REQ-019 SHALL, in DATA on baud_tick: if bit_cnt>0, decrement and drive the next bit; if bit_cnt=0, go to PARITY with tx<=parity when PARITY_EN=1, else go to STOP with tx<=1.
REQ-020 SHALL, in PARITY on baud_tick: set tx<=1 and go to STOP.
REQ-021 SHALL, in STOP on baud_tick: pulse tx_done for one clk; if the FIFO is non-empty, pop, set tx<=0 and go to START (back-to-back, no idle period); else go to IDLE with tx=1.
REQ-022 SHALL ignore baud_tick in IDLE with an empty FIFO and keep tx=1.
REQ-023 SHALL, on a simultaneous push and pop with the FIFO non-full, execute both and leave the count unchanged.
REQ-024 SHALL, on a push into an empty FIFO in the same cycle as an IDLE baud_tick, not start a frame that cycle; the frame starts on the next baud_tick.
REQ-025 SHALL wrap the FIFO read/write pointers modulo FIFO_DEPTH, with full/empty derived from an extra wrap bit.
REQ-026 SHALL register tx, with no combinational path from any input to tx.
REQ-027 SHALL hold the shift register stable if in_data changes after acceptance.

Reset
REQ-028 SHALL, while reset=0, immediately force: tx=1, in_ready=0, busy=0, tx_done=0, state=IDLE, FIFO empty, bit_cnt=0.
REQ-029 SHALL, on reset mid-frame, abandon the frame, discard FIFO contents, and not assert tx_done.
REQ-030 SHALL assert in_ready=1 on the first clk edge after reset deasserts.

Structure
REQ-031 SHALL place in package uart_pkg: the state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), UART_DATA_W=8, and START_BIT=0 and STOP_BIT=1.
REQ-032 SHALL implement the FIFO as sub-module uart_tx_fifo (sync, single clock, push/pop/full/empty/count), with the FSM and shifter in uart_tx.

Verification
REQ-033 SHALL verify single byte: push 0xA5, PARITY_EN=1 -> tx per tick 0,1,0,1,0,0,1,0,1,0,1, then one tx_done and busy=0.
REQ-034 SHALL verify back-to-back: push 0x00 and 0xFF -> frames 0,00000000,0,1 and 0,11111111,0,1 with no idle bit between them and two tx_done pulses.
REQ-035 SHALL verify full FIFO: 5 pushes with FIFO_DEPTH=4 and no ticks -> in_ready=0 after the 4th, the 5th is dropped, and exactly 4 frames are transmitted.
REQ-036 SHALL verify PARITY_EN=0: push 0x81 -> tx 0,1,0,0,0,0,0,0,1,1 (10 periods).
REQ-037 SHALL verify reset mid-frame: assert reset during DATA bit 3 -> tx=1 immediately, FIFO empty, no tx_done, and a clean 0x3C frame after release.
REQ-038 SHALL verify tick gaps: baud_tick every 16 clks with random stalls -> tx changes only on tick edges and frame content is unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: frame constants, FSM state encoding
// and the parity helper.
package uart_pkg;

    localparam int   UART_DATA_W = 8;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Even parity over the data bits only: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock holding FIFO for bytes waiting to be transmitted. Read data is
// show-ahead: rdata always presents the oldest entry while the FIFO is non-empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [UART_DATA_W-1:0] wdata,
    output logic [UART_DATA_W-1:0] rdata,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            count
);

    logic [UART_DATA_W-1:0] mem_r [DEPTH];
    logic [AW:0]            wr_ptr_r;
    logic [AW:0]            rd_ptr_r;
    logic                   push_en_s;
    logic                   pop_en_s;

    // The top pointer bit is a wrap flag: equal low bits with differing wrap flags means full.
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign count     = wr_ptr_r - rd_ptr_r;
    assign rdata     = mem_r[rd_ptr_r[AW-1:0]];
    assign push_en_s = push && !full;
    assign pop_en_s  = pop && !empty;

    // Pointer and storage update; pointers wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_en_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wdata;
                wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: bytes queue in a holding FIFO and are shifted out MSB-first as
// start / 8 data / optional even parity / stop, advancing only on baud_tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   baud_tick,
    input  logic [UART_DATA_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy,
    output logic                   tx_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    uart_state_e            state_r;
    logic [UART_DATA_W-1:0] shift_r;
    logic [2:0]             bit_cnt_r;
    logic                   tx_r;
    logic                   tx_done_r;
    logic                   busy_r;
    logic                   in_ready_r;

    logic                   push_s;
    logic                   pop_s;
    logic [UART_DATA_W-1:0] fifo_rdata_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [CW-1:0]          fifo_count_s;
    logic [CW-1:0]          count_next_s;

    assign push_s       = in_valid && in_ready_r && !fifo_full_s;
    assign count_next_s = fifo_count_s + CW'(push_s) - CW'(pop_s);

    assign tx       = tx_r;
    assign tx_done  = tx_done_r;
    assign busy     = busy_r;
    assign in_ready = in_ready_r;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (in_data),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // A byte leaves the FIFO only at a frame boundary (IDLE or end of STOP) on a tick.
    always_comb begin
        pop_s = 1'b0;
        if (baud_tick && !fifo_empty_s && ((state_r == IDLE) || (state_r == STOP))) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // in_ready mirrors "not full" for the coming cycle, computed from the post-edge occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_r <= 1'b0;
        end else begin
            in_ready_r <= (count_next_s != CW'(FIFO_DEPTH));
        end
    end

    // Frame sequencer and shifter; tx, tx_done and busy are all registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            shift_r   <= '0;
            bit_cnt_r <= 3'd0;
            tx_r      <= STOP_BIT;
            tx_done_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            busy_r    <= (state_r != IDLE) || (count_next_s != '0);
            if (baud_tick) begin
                case (state_r)
                    IDLE: begin
                        if (!fifo_empty_s) begin
                            shift_r   <= fifo_rdata_s;
                            bit_cnt_r <= 3'd7;
                            tx_r      <= START_BIT;
                            state_r   <= START;
                            busy_r    <= 1'b1;
                        end else begin
                            tx_r <= STOP_BIT;
                        end
                    end
                    START: begin
                        tx_r    <= shift_r[7];
                        state_r <= DATA;
                    end
                    DATA: begin
                        if (bit_cnt_r != 3'd0) begin
                            bit_cnt_r <= bit_cnt_r - 3'd1;
                            tx_r      <= shift_r[bit_cnt_r - 3'd1];
                        end else if (PARITY_EN != 0) begin
                            tx_r    <= even_parity(shift_r);
                            state_r <= PARITY;
                        end else begin
                            tx_r    <= STOP_BIT;
                            state_r <= STOP;
                        end
                    end
                    PARITY: begin
                        tx_r    <= STOP_BIT;
                        state_r <= STOP;
                    end
                    STOP: begin
                        tx_done_r <= 1'b1;
                        // Chain straight into the next start bit when another byte is waiting.
                        if (!fifo_empty_s) begin
                            shift_r   <= fifo_rdata_s;
                            bit_cnt_r <= 3'd7;
                            tx_r      <= START_BIT;
                            state_r   <= START;
                        end else begin
                            tx_r    <= STOP_BIT;
                            state_r <= IDLE;
                            busy_r  <= (count_next_s != '0);
                        end
                    end
                    default: begin
                        tx_r    <= STOP_BIT;
                        state_r <= IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: expected line levels are queued per baud tick when
// bytes are pushed and compared by a monitor after every tick edge.
module tb_uart_tx;

    logic       clk         = 1'b0;
    logic       reset       = 1'b1;
    logic       baud_tick   = 1'b0;
    logic [7:0] in_data     = 8'h00;
    logic       in_valid    = 1'b0;
    logic [7:0] in_data_np  = 8'h00;
    logic       in_valid_np = 1'b0;

    logic in_ready, tx, busy, tx_done;
    logic in_ready_np, tx_np, busy_np, tx_done_np;

    int checks      = 0;
    int errors      = 0;
    int done_cnt    = 0;
    int done_np_cnt = 0;

    bit exp_q[$];
    bit exp_np_q[$];

    uart_tx #(.FIFO_DEPTH(4), .PARITY_EN(1)) dut (
        .clk(clk), .reset(reset), .baud_tick(baud_tick),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    uart_tx #(.FIFO_DEPTH(4), .PARITY_EN(0)) dut_np (
        .clk(clk), .reset(reset), .baud_tick(baud_tick),
        .in_data(in_data_np), .in_valid(in_valid_np), .in_ready(in_ready_np),
        .tx(tx_np), .busy(busy_np), .tx_done(tx_done_np)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: after each tick edge pop the expected level (idle 1 if none),
    // otherwise require tx to hold; also count tx_done pulses.
    logic tx_prev = 1'b1, tx_np_prev = 1'b1, rst_prev = 1'b0;
    always @(posedge clk) begin : monitor
        logic tick_s, rst_s, exp_b, exp_np_b;
        tick_s = baud_tick;
        rst_s  = reset;
        #2;
        if (rst_s && reset) begin
            if (tick_s) begin
                exp_b    = (exp_q.size() > 0)    ? exp_q.pop_front()    : 1'b1;
                exp_np_b = (exp_np_q.size() > 0) ? exp_np_q.pop_front() : 1'b1;
                checks += 2;
                if (tx !== exp_b) begin
                    errors++;
                    $display("FAIL tx_bit: tx=%b expected=%b at %0t", tx, exp_b, $time);
                end
                if (tx_np !== exp_np_b) begin
                    errors++;
                    $display("FAIL tx_np_bit: tx_np=%b expected=%b at %0t", tx_np, exp_np_b, $time);
                end
            end else if (rst_prev) begin
                checks++;
                if ((tx !== tx_prev) || (tx_np !== tx_np_prev)) begin
                    errors++;
                    $display("FAIL tx_no_tick: tx %b->%b tx_np %b->%b without tick at %0t",
                             tx_prev, tx, tx_np_prev, tx_np, $time);
                end
            end
            if (tx_done === 1'b1)    done_cnt++;
            if (tx_done_np === 1'b1) done_np_cnt++;
        end
        rst_prev   = rst_s && reset;
        tx_prev    = tx;
        tx_np_prev = tx_np;
    end

    task automatic enqueue_frame(input logic [7:0] b, input bit to_np);
        if (to_np) begin
            exp_np_q.push_back(1'b0);
            for (int i = 7; i >= 0; i--) exp_np_q.push_back(b[i]);
            exp_np_q.push_back(1'b1);
        end else begin
            exp_q.push_back(1'b0);
            for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
            exp_q.push_back(^b);
            exp_q.push_back(1'b1);
        end
    endtask

    task automatic tick(input int gap);
        repeat (gap) @(negedge clk);
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
    endtask

    task automatic run_ticks(input int n, input int gmin, input int gmax);
        for (int i = 0; i < n; i++) tick(int'($urandom_range(gmax, gmin)));
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~b;
    endtask

    task automatic push_with_tick(input logic [7:0] b);
        @(negedge clk);
        in_data   = b;
        in_valid  = 1'b1;
        baud_tick = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        baud_tick = 1'b0;
        in_data   = ~b;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        checks += 5;
        if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx: tx=%b expected=1", tx); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: in_ready=%b expected=0", in_ready); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: busy=%b expected=0", busy); end
        if (tx_done !== 1'b0)  begin errors++; $display("FAIL reset_tx_done: tx_done=%b expected=0", tx_done); end
        if (tx_np !== 1'b1)    begin errors++; $display("FAIL reset_tx_np: tx_np=%b expected=1", tx_np); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: in_ready=%b expected=0", in_ready); end
        @(negedge clk);
        checks += 3;
        if (in_ready !== 1'b1)    begin errors++; $display("FAIL ready_after_reset: in_ready=%b expected=1", in_ready); end
        if (in_ready_np !== 1'b1) begin errors++; $display("FAIL ready_np_after_reset: in_ready_np=%b expected=1", in_ready_np); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL busy_after_reset: busy=%b expected=0", busy); end
    endtask

    task automatic test_idle_tick();
        run_ticks(3, 1, 3);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: busy=%b expected=0", busy); end
    endtask

    task automatic test_single_byte();
        int d0;
        d0 = done_cnt;
        push(8'hA5);
        enqueue_frame(8'hA5, 1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: busy=%b expected=1", busy); end
        run_ticks(11, 1, 3);
        checks++;
        if (done_cnt !== d0) begin errors++; $display("FAIL single_early_done: done=%0d expected=%0d", done_cnt - d0, 0); end
        tick(2);
        checks += 2;
        if (done_cnt !== d0 + 1) begin errors++; $display("FAIL single_done: done=%0d expected=1", done_cnt - d0); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL single_busy_end: busy=%b expected=0", busy); end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        push(8'h00);
        push(8'hFF);
        enqueue_frame(8'h00, 1'b0);
        enqueue_frame(8'hFF, 1'b0);
        run_ticks(23, 1, 3);
        checks += 2;
        if (done_cnt !== d0 + 2) begin errors++; $display("FAIL b2b_done: done=%0d expected=2", done_cnt - d0); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL b2b_busy: busy=%b expected=0", busy); end
    endtask

    task automatic test_full_fifo();
        logic [7:0] bytes [5];
        int d0;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== ((i < 4) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL full_ready_%0d: in_ready=%b expected=%b", i, in_ready, (i < 4));
            end
            push(bytes[i]);
            if (i < 4) enqueue_frame(bytes[i], 1'b0);
        end
        run_ticks(45, 1, 3);
        checks += 3;
        if (done_cnt !== d0 + 4) begin errors++; $display("FAIL full_done: done=%0d expected=4", done_cnt - d0); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL full_busy: busy=%b expected=0", busy); end
        if (in_ready !== 1'b1)   begin errors++; $display("FAIL full_ready_end: in_ready=%b expected=1", in_ready); end
    endtask

    task automatic test_no_parity();
        int d0;
        d0 = done_np_cnt;
        @(negedge clk);
        in_data_np  = 8'h81;
        in_valid_np = 1'b1;
        @(negedge clk);
        in_valid_np = 1'b0;
        in_data_np  = 8'h7E;
        enqueue_frame(8'h81, 1'b1);
        run_ticks(11, 1, 3);
        checks += 2;
        if (done_np_cnt !== d0 + 1) begin errors++; $display("FAIL np_done: done=%0d expected=1", done_np_cnt - d0); end
        if (busy_np !== 1'b0)       begin errors++; $display("FAIL np_busy: busy_np=%b expected=0", busy_np); end
    endtask

    task automatic test_push_on_tick();
        int d0;
        d0 = done_cnt;
        push_with_tick(8'h96);
        enqueue_frame(8'h96, 1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL pot_busy: busy=%b expected=1", busy); end
        run_ticks(12, 1, 3);
        checks++;
        if (done_cnt !== d0 + 1) begin errors++; $display("FAIL pot_done: done=%0d expected=1", done_cnt - d0); end
    endtask

    task automatic test_push_pop();
        int d0;
        d0 = done_cnt;
        push(8'hC3);
        enqueue_frame(8'hC3, 1'b0);
        push_with_tick(8'h5E);
        enqueue_frame(8'h5E, 1'b0);
        run_ticks(22, 1, 3);
        checks += 2;
        if (done_cnt !== d0 + 2) begin errors++; $display("FAIL pp_done: done=%0d expected=2", done_cnt - d0); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL pp_busy: busy=%b expected=0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        push(8'hA5);
        push(8'h0F);
        enqueue_frame(8'hA5, 1'b0);
        run_ticks(6, 2, 3);
        d0 = done_cnt;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks += 4;
        if (tx !== 1'b1)       begin errors++; $display("FAIL rmf_tx: tx=%b expected=1", tx); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL rmf_busy: busy=%b expected=0", busy); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rmf_ready: in_ready=%b expected=0", in_ready); end
        if (tx_done !== 1'b0)  begin errors++; $display("FAIL rmf_tx_done: tx_done=%b expected=0", tx_done); end
        exp_q.delete();
        run_ticks(2, 1, 2);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks += 2;
        if (busy !== 1'b0)     begin errors++; $display("FAIL rmf_empty: busy=%b expected=0", busy); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rmf_ready_release: in_ready=%b expected=1", in_ready); end
        run_ticks(3, 1, 3);
        push(8'h3C);
        enqueue_frame(8'h3C, 1'b0);
        run_ticks(12, 1, 3);
        checks += 2;
        if (done_cnt !== d0 + 1) begin errors++; $display("FAIL rmf_done: done=%0d expected=1", done_cnt - d0); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL rmf_busy_end: busy=%b expected=0", busy); end
    endtask

    task automatic test_tick_gaps();
        int d0;
        d0 = done_cnt;
        push(8'hE7);
        push(8'h18);
        enqueue_frame(8'hE7, 1'b0);
        enqueue_frame(8'h18, 1'b0);
        run_ticks(23, 16, 40);
        checks += 2;
        if (done_cnt !== d0 + 2) begin errors++; $display("FAIL gaps_done: done=%0d expected=2", done_cnt - d0); end
        if (exp_q.size() != 0)   begin errors++; $display("FAIL gaps_leftover: remaining=%0d expected=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_idle_tick();
        test_single_byte();
        test_back_to_back();
        test_full_fifo();
        test_no_parity();
        test_push_on_tick();
        test_push_pop();
        test_reset_mid_frame();
        test_tick_gaps();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
